// File: rtl/beta_crypt_mem_port.sv
// Multi-cycle encrypted data-memory port: iterative rotate/XOR round engine between
// the Beta core and Data_Memory, with a valid/ready request handshake.
module beta_crypt_mem_port #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 32,
  parameter int                 BLOCK_W = 128,
  parameter int                 ROUNDS  = 4,
  parameter int                 ROT     = 7,
  parameter logic [BLOCK_W-1:0] KEY     = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0]  req_wd,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rd,
  output logic               busy,
  output logic [ADDR_W-1:0]  mem_adr,
  output logic [BLOCK_W-1:0] mem_wd,
  output logic               mem_wr,
  output logic               mem_oe,
  input  logic [BLOCK_W-1:0] mem_rd
);

  localparam int CNT_W = (ROUNDS < 2) ? 1 : $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {IDLE, ENC, WRITE, READ, DEC, RESP} state_t;

  state_t             state_reg, state_next;
  logic [BLOCK_W-1:0] s_reg;
  logic [CNT_W-1:0]   rcnt_reg;
  logic [ADDR_W-1:0]  mem_adr_reg;
  logic [DATA_W-1:0]  rsp_rd_reg;

  logic [BLOCK_W-1:0] enc_s, dec_s, enc_x;
  logic               last_round;

  // With ROT=0 the complementary shift is by BLOCK_W, which yields zero, so no special case.
  assign enc_x      = s_reg ^ KEY;
  assign enc_s      = (enc_x << ROT) | (enc_x >> (BLOCK_W - ROT));
  assign dec_s      = ((s_reg >> ROT) | (s_reg << (BLOCK_W - ROT))) ^ KEY;
  assign last_round = (rcnt_reg == CNT_W'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_we ? ENC : READ;
      ENC:     if (last_round) state_next = WRITE;
      WRITE:   state_next = RESP;
      READ:    state_next = DEC;
      DEC:     if (last_round) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    busy      = (state_reg != IDLE);
    rsp_valid = (state_reg == RESP);
    mem_wr    = (state_reg == WRITE);
    mem_oe    = (state_reg == READ);
    mem_wd    = (state_reg == WRITE) ? s_reg : '0;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      s_reg       <= '0;
      rcnt_reg    <= '0;
      mem_adr_reg <= '0;
      rsp_rd_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (req_valid) begin
          mem_adr_reg <= req_adr;
          if (req_we) begin
            s_reg    <= BLOCK_W'(req_wd);
            rcnt_reg <= '0;
          end
        end
        ENC: begin
          s_reg    <= enc_s;
          rcnt_reg <= rcnt_reg + 1'b1;
        end
        WRITE: rsp_rd_reg <= '0;
        READ: begin
          s_reg    <= mem_rd;
          rcnt_reg <= '0;
        end
        DEC: begin
          s_reg    <= dec_s;
          rcnt_reg <= rcnt_reg + 1'b1;
          // Capture the post-round value so rsp_rd is ready when RESP begins.
          if (last_round) rsp_rd_reg <= dec_s[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign mem_adr = mem_adr_reg;
  assign rsp_rd  = rsp_rd_reg;

endmodule

// File: tb/tb_beta_crypt_mem_port.sv
// Directed bench for beta_crypt_mem_port: three instances with different cipher settings.
module tb_beta_crypt_mem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RESET;
  logic [2:0]  req_valid;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wd;
  logic [127:0] mem_rd_drv [3];

  wire [2:0]   req_ready, rsp_valid, busy, mem_wr, mem_oe;
  wire [31:0]  rsp_rd  [3];
  wire [31:0]  mem_adr [3];
  wire [127:0] mem_wd  [3];
  wire [127:0] mem_rd_w [3];

  logic [127:0] mem_model [16];

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 0: KEY=0 ROT=8 R=4; instance 1: KEY=FF ROT=0 R=1; instance 2: defaults.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam logic [127:0] KEY_G = (gi == 0) ? 128'h0 :
                                       (gi == 1) ? 128'hFF :
                                       128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      localparam int ROT_G    = (gi == 0) ? 8 : (gi == 1) ? 0 : 7;
      localparam int ROUNDS_G = (gi == 1) ? 1 : 4;
      if (gi == 2) begin : g_mem
        assign mem_rd_w[gi] = mem_model[mem_adr[gi][3:0]];
      end else begin : g_drv
        assign mem_rd_w[gi] = mem_rd_drv[gi];
      end
      beta_crypt_mem_port #(
        .DATA_W(32), .ADDR_W(32), .BLOCK_W(128),
        .ROUNDS(ROUNDS_G), .ROT(ROT_G), .KEY(KEY_G)
      ) u_dut (
        .clk(clk), .RESET(RESET),
        .req_valid(req_valid[gi]), .req_ready(req_ready[gi]),
        .req_we(req_we), .req_adr(req_adr), .req_wd(req_wd),
        .rsp_valid(rsp_valid[gi]), .rsp_rd(rsp_rd[gi]), .busy(busy[gi]),
        .mem_adr(mem_adr[gi]), .mem_wd(mem_wd[gi]),
        .mem_wr(mem_wr[gi]), .mem_oe(mem_oe[gi]), .mem_rd(mem_rd_w[gi])
      );
    end
  endgenerate

  always @(posedge clk) begin
    if (mem_wr[2]) mem_model[mem_adr[2][3:0]] <= mem_wd[2];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] x, input logic [127:0] key,
                                           input int rot, input int rounds);
    logic [127:0] s = x;
    for (int r = 0; r < rounds; r++) begin
      s = s ^ key;
      if (rot != 0) s = (s << rot) | (s >> (128 - rot));
    end
    return s;
  endfunction

  task automatic txn(input int d, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                     input logic disturb, output int lat, output logic [31:0] rd,
                     output logic [127:0] wseen, output logic [31:0] aseen,
                     output int wr_cnt, output int busy_cnt);
    check("ready_before", 128'(req_ready[d]), 128'd1);
    req_valid[d] = 1'b1;
    req_we = we; req_adr = adr; req_wd = wd;
    @(posedge clk); #1;
    lat = -1; rd = '0; wseen = '0; aseen = '0; wr_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (disturb && n == 1) begin
        req_adr = adr + 32'd4;
        req_wd  = ~wd;
      end
      if (busy[d]) busy_cnt++;
      if (mem_wr[d]) begin wr_cnt++; wseen = mem_wd[d]; aseen = mem_adr[d]; end
      if (mem_oe[d]) aseen = mem_adr[d];
      if (rsp_valid[d]) begin
        lat = n; rd = rsp_rd[d]; req_valid[d] = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      check("rsp_timeout", 128'd0, 128'd1);
      req_valid[d] = 1'b0;
    end
    @(posedge clk); #1;
    check("ready_after_rsp", 128'(req_ready[d]), 128'd1);
    $display("txn dut=%0d we=%0b adr=%0h wd=%0h lat=%0d rd=%0h mem_wd=%0h", d, we, adr, wd, lat, rd, wseen);
  endtask

  int lat, wr_cnt, busy_cnt, bad;
  logic [31:0] rd, aseen;
  logic [127:0] wseen, exp_ct;

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    for (int i = 0; i < 3; i++) mem_rd_drv[i] = '0;
    RESET = 1'b1; req_valid = '0; req_we = 1'b0; req_adr = '0; req_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   128'(req_ready), 128'h7);
    check("rst_busy",    128'(busy),      128'h0);
    check("rst_rsp",     128'(rsp_valid), 128'h0);
    check("rst_wr",      128'(mem_wr),    128'h0);
    check("rst_oe",      128'(mem_oe),    128'h0);
    check("rst_wd",      mem_wd[0],       128'h0);
    check("rst_adr",     128'(mem_adr[0]), 128'h0);
    check("rst_rd",      128'(rsp_rd[0]), 128'h0);
    RESET = 1'b0;
    @(posedge clk); #1;

    // Rotate-only cipher: 4 rounds of rotl 8 is a 32-bit left shift.
    txn(0, 1'b1, 32'd5, 32'hAB, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t1_lat", 128'(lat), 128'd6);
    check("t1_wrcnt", 128'(wr_cnt), 128'd1);
    check("t1_adr", 128'(aseen), 128'd5);
    check("t1_wd", wseen, 128'hAB << 32);
    check("t1_rd_zero", 128'(rd), 128'd0);
    mem_rd_drv[0] = 128'hAB << 32;
    txn(0, 1'b0, 32'd5, 32'h0, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t2_lat", 128'(lat), 128'd6);
    check("t2_rd", 128'(rd), 128'hAB);
    check("t2_wrcnt", 128'(wr_cnt), 128'd0);

    // XOR-only cipher, single round: 0x12 ^ 0xFF = 0xED.
    txn(1, 1'b1, 32'd1, 32'h12, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t3_lat_w", 128'(lat), 128'd3);
    check("t3_wd", wseen, 128'hED);
    mem_rd_drv[1] = 128'hED;
    txn(1, 1'b0, 32'd1, 32'h0, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t3_lat_r", 128'(lat), 128'd3);
    check("t3_rd", 128'(rd), 128'h12);

    // Default cipher round trip through the model memory.
    exp_ct = ref_enc(128'hDEADBEEF, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 7, 4);
    txn(2, 1'b1, 32'd9, 32'hDEADBEEF, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t4_lat_w", 128'(lat), 128'd6);
    check("t4_busy_w", 128'(busy_cnt), 128'd6);
    check("t4_ct", wseen, exp_ct);
    check("t4_mem", mem_model[9], exp_ct);
    txn(2, 1'b0, 32'd9, 32'h0, 1'b0, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t4_lat_r", 128'(lat), 128'd6);
    check("t4_busy_r", 128'(busy_cnt), 128'd6);
    check("t4_rd", 128'(rd), 128'hDEADBEEF);

    // Reset during ENC cycle 2, held with req_valid asserted.
    req_valid[0] = 1'b1; req_we = 1'b1; req_adr = 32'd2; req_wd = 32'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    RESET = 1'b1;
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (req_ready[0] !== 1'b1 || mem_wr[0] !== 1'b0 || rsp_valid[0] !== 1'b0) bad++;
    end
    check("t5_rst_idle", 128'(bad), 128'd0);
    RESET = 1'b0; req_valid[0] = 1'b0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (mem_wr[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    check("t5_no_activity", 128'(bad), 128'd0);
    $display("txn dut=0 reset_abort strobes_bad=%0d", bad);

    // Request inputs change while busy: the accepted transaction is unaffected.
    txn(0, 1'b1, 32'd3, 32'h55, 1'b1, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t6_adr", 128'(aseen), 128'd3);
    check("t6_wd", wseen, 128'h55 << 32);
    check("t6_wrcnt", 128'(wr_cnt), 128'd1);
    mem_rd_drv[0] = 128'h55 << 32;
    txn(0, 1'b0, 32'd3, 32'h0, 1'b1, lat, rd, wseen, aseen, wr_cnt, busy_cnt);
    check("t6_rd_adr", 128'(aseen), 128'd3);
    check("t6_rd", 128'(rd), 128'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
